ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, sitting directly upstream of the execute-stage ALU.
- Latches decoded instruction fields from ID each cycle.
- Drives the ALU operands and the 4-bit ALU control code, forwarding results from EX/MEM and MEM/WB.
- Detects load-use hazards, inserts bubbles, and honours the global hold and flush controls.

Parameters:
- XLEN, 32, data/operand width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- hold_i  in  1  downstream stall; freeze the EX register
- flush_i  in  1  branch redirect; kill the EX register contents
- id_valid  in  1  ID holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded operands
- id_rs1, id_rs2, id_rd  in  REG_AW each  register indices
- id_uses_rs2  in  1  instruction reads rs2 (R-type, store, branch)
- id_a_pc  in  1  operand A = PC (auipc/jal)
- id_alu_src  in  1  operand B = imm
- id_alu_op  in  2  00 add, 01 sub, 10 R-type, 11 I-type ALU
- id_funct3  in  3  instruction funct3
- id_funct7_5  in  1  instruction bit 30
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  control bits
- exmem_reg_write  in  1, exmem_rd  in  REG_AW, exmem_result  in  XLEN  EX/MEM forward source
- memwb_reg_write  in  1, memwb_rd  in  REG_AW, memwb_result  in  XLEN  MEM/WB forward source
- ALU_A, ALU_B  out  XLEN each  ALU operands (combinational from registered state plus forward inputs)
- ALU_Control  out  4  registered ALU operation code
- ex_store_data  out  XLEN  forwarded rs2 value, used for stores
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each  registered control bits
- ex_rd  out  REG_AW  registered destination index
- ex_pc, ex_imm  out  XLEN each  registered PC and immediate
- stall_o  out  1  freeze PC and the IF/ID register

Behaviour:
- Reset (async, rst_n=0):
  - All registered fields cleared to 0; ALU_Control = 0010 (ADD).
  - ALU_A/ALU_B therefore read 0; stall_o = 0.
- Per-edge update priority:
  1. flush_i → load a bubble.
  2. Else hold_i → keep all registered fields.
  3. Else load_use → load a bubble.
  4. Else capture the ID fields, with ex_valid = id_valid.
- Bubble definition:
  - valid, reg_write, mem_read, mem_write, branch and mem_to_reg all 0.
  - rs1, rs2, rd = 0; data fields = 0; ALU_Control = 0010.
- load_use (combinational):
  - Asserted when id_valid & ex_valid & ex_mem_read & ex_rd≠0.
  - And either ex_rd==id_rs1, or (id_uses_rs2 & ex_rd==id_rs2).
- stall_o = (load_use | hold_i) & ~flush_i.
- Load-use latency: exactly one bubble cycle. On the next cycle the load is in MEM/WB and MEM/WB forwarding supplies the data.
- ALU_Control decode, performed at capture time and registered:
  - alu_op 00 → 0010 (ADD); 01 → 0110 (SUB).
  - alu_op 10 (R-type): funct3 000 → 0010 if funct7_5=0, 0110 if 1; 111 → 0000; 110 → 0001; 010 → 0111; any other funct3 → 1111.
  - alu_op 11 (I-type): funct3 000 → 0010, with funct7_5 ignored; 111/110/010 as for R-type; any other → 1111.
  - 1111 makes the ALU output 0. 1100 (NOR) is never generated.
- Forwarding, applied independently to rs1 and rs2 (sub-module):
  - Source 1 is EX/MEM when exmem_reg_write & exmem_rd≠0 & exmem_rd==idx.
  - Otherwise source 2 is MEM/WB when memwb_reg_write & memwb_rd≠0 & memwb_rd==idx.
  - Otherwise the registered register-file data is used.
  - EX/MEM has priority. Index 0 never forwards.
- Operand selection:
  - ALU_A = ex_a_pc ? ex_pc : fwd_rs1.
  - ALU_B = ex_alu_src ? ex_imm : fwd_rs2.
  - ex_store_data = fwd_rs2 regardless of alu_src.
- Forwarding is evaluated even while hold_i is asserted, so operands track late writebacks during a hold.
- Mid-operation reset clears immediately; there is no partial state.

Decomposition:
- Shared package core_pkg:
  - ALU code constants ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100, ALU_ILL=1111.
  - ALUOP_* encodings.
  - XLEN and REG_AW.
- Sub-module ex_forward_unit: purely combinational forwarding for one register index. Instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Reset then idle: rst_n low mid-cycle → all outputs 0 and ALU_Control=0010 immediately, without waiting for a clock edge.
- R-type decode: funct3=000, funct7_5=1, alu_op=10, rs1_data=9, rs2_data=4 → next cycle ALU_Control=0110, ALU_A=9, ALU_B=4.
- Double forward: exmem_rd=5 (result 0x11) and memwb_rd=5 (result 0x22) both writing, EX rs1=5 → ALU_A=0x11. With exmem_rd=0 instead → ALU_A=0x22.
- Load-use hazard:
  - EX holds lw x7 (mem_read=1, rd=7); ID holds add with rs2=7, uses_rs2=1.
  - Expect stall_o=1 for one cycle, then a bubble (ex_valid=0) enters EX.
  - Next cycle the add enters EX with ALU_B = memwb_result.
- Flush over hold: flush_i=1 and hold_i=1 together → ex_valid=0, ex_reg_write=0, stall_o=0.
- I-type illegal funct3: alu_op=11, funct3=001 → ALU_Control=1111. ADDI with funct7_5=1 → 0010.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, ALU control codes, ALU-op
// encodings, the ID/EX register payload and the ALU control decoder.
package core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_ILL = 4'b1111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // Contents of the ID/EX pipeline register.
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic              a_pc;
        logic              alu_src;
        logic [3:0]        alu_ctrl;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
    } ex_reg_t;

    // A bubble is all-zero except the ALU code, which idles at ADD.
    function automatic ex_reg_t ex_bubble();
        ex_reg_t b;
        b          = '0;
        b.alu_ctrl = ALU_ADD;
        return b;
    endfunction

    // Maps alu_op/funct3/funct7[5] to the 4-bit ALU control code.
    function automatic logic [3:0] alu_decode(input logic [1:0] op,
                                              input logic [2:0] funct3,
                                              input logic       funct7_5);
        logic [3:0] code;
        code = ALU_ILL;
        case (op)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000: code = (op == ALUOP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b111: code = ALU_AND;
                    3'b110: code = ALU_OR;
                    3'b010: code = ALU_SLT;
                    default: code = ALU_ILL;
                endcase
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ex_forward_unit.sv
// Combinational operand forwarding for one register index.
// Ports: idx_i (source register index), rf_data_i (value read in ID),
//        exmem_*/memwb_* (writeback candidates), data_o (forwarded value).
module ex_forward_unit
    import core_pkg::*;
(
    input  logic [REG_AW-1:0] idx_i,
    input  logic [XLEN-1:0]   rf_data_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic [XLEN-1:0]   exmem_result_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic [XLEN-1:0]   memwb_result_i,
    output logic [XLEN-1:0]   data_o
);

    logic hit_exmem;
    logic hit_memwb;

    // x0 is hard-wired zero, so a write to it must never be forwarded.
    assign hit_exmem = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == idx_i);
    assign hit_memwb = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == idx_i);

    // The younger EX/MEM result wins over MEM/WB.
    always_comb begin
        data_o = rf_data_i;
        if (hit_exmem) begin
            data_o = exmem_result_i;
        end else if (hit_memwb) begin
            data_o = memwb_result_i;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the execute-stage ALU: latches decoded
// fields, decodes the ALU control code, forwards from EX/MEM and MEM/WB,
// and inserts bubbles on load-use hazards, flush and hold.
// Ports: clk/rst_n; hold_i/flush_i global controls; id_* decoded fields;
//        exmem_*/memwb_* forward sources; ALU_A/ALU_B/ex_store_data
//        combinational operands; ALU_Control and ex_* registered fields;
//        stall_o freezes PC and IF/ID.
module ex_operand_stage
    import core_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs2,
    input  logic              id_a_pc,
    input  logic              id_alu_src,
    input  logic [1:0]        id_alu_op,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7_5,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_result,
    output logic [XLEN-1:0]   ALU_A,
    output logic [XLEN-1:0]   ALU_B,
    output logic [3:0]        ALU_Control,
    output logic [XLEN-1:0]   ex_store_data,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic [REG_AW-1:0] ex_rd,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic              stall_o
);

    ex_reg_t         ex_q;
    ex_reg_t         ex_d;
    ex_reg_t         id_fields;
    logic            load_use;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    // A load in EX whose destination is read by the instruction in ID.
    assign load_use = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                      ((ex_q.rd == id_rs1) || (id_uses_rs2 && (ex_q.rd == id_rs2)));

    assign stall_o = (load_use || hold_i) && !flush_i;

    // Pack the ID fields, decoding the ALU code at capture time.
    always_comb begin
        id_fields            = '0;
        id_fields.valid      = id_valid;
        id_fields.reg_write  = id_reg_write;
        id_fields.mem_read   = id_mem_read;
        id_fields.mem_write  = id_mem_write;
        id_fields.mem_to_reg = id_mem_to_reg;
        id_fields.branch     = id_branch;
        id_fields.a_pc       = id_a_pc;
        id_fields.alu_src    = id_alu_src;
        id_fields.alu_ctrl   = alu_decode(id_alu_op, id_funct3, id_funct7_5);
        id_fields.rd         = id_rd;
        id_fields.rs1        = id_rs1;
        id_fields.rs2        = id_rs2;
        id_fields.pc         = id_pc;
        id_fields.imm        = id_imm;
        id_fields.rs1_data   = id_rs1_data;
        id_fields.rs2_data   = id_rs2_data;
    end

    // Next-state priority: flush, hold, load-use bubble, capture.
    always_comb begin
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = ex_bubble();
        end else if (hold_i) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = ex_bubble();
        end else begin
            ex_d = id_fields;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= ex_bubble();
        end else begin
            ex_q <= ex_d;
        end
    end

    ex_forward_unit u_fwd_rs1 (
        .idx_i             (ex_q.rs1),
        .rf_data_i         (ex_q.rs1_data),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_result_i    (exmem_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_result_i    (memwb_result),
        .data_o            (fwd_rs1)
    );

    ex_forward_unit u_fwd_rs2 (
        .idx_i             (ex_q.rs2),
        .rf_data_i         (ex_q.rs2_data),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_i        (exmem_rd),
        .exmem_result_i    (exmem_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_i        (memwb_rd),
        .memwb_result_i    (memwb_result),
        .data_o            (fwd_rs2)
    );

    assign ALU_A         = ex_q.a_pc    ? ex_q.pc  : fwd_rs1;
    assign ALU_B         = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    assign ex_store_data = fwd_rs2;

    assign ALU_Control   = ex_q.alu_ctrl;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;
    assign ex_rd         = ex_q.rd;
    assign ex_pc         = ex_q.pc;
    assign ex_imm        = ex_q.imm;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: stimulus queues expected values
// tagged with the sampling cycle; a monitor on the falling edge compares.
module tb_ex_operand_stage;
    import core_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hold_i, flush_i;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_uses_rs2, id_a_pc, id_alu_src;
    logic [1:0]        id_alu_op;
    logic [2:0]        id_funct3;
    logic              id_funct7_5;
    logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] exmem_rd;
    logic [XLEN-1:0]   exmem_result;
    logic              memwb_reg_write;
    logic [REG_AW-1:0] memwb_rd;
    logic [XLEN-1:0]   memwb_result;
    logic [XLEN-1:0]   ALU_A, ALU_B, ex_store_data, ex_pc, ex_imm;
    logic [3:0]        ALU_Control;
    logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
    logic [REG_AW-1:0] ex_rd;
    logic              stall_o;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_uses_rs2(id_uses_rs2),
        .id_a_pc(id_a_pc), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_branch(id_branch),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Control(ALU_Control),
        .ex_store_data(ex_store_data), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_branch(ex_branch), .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    localparam int S_A = 0, S_B = 1, S_CTL = 2, S_VLD = 3, S_STALL = 4,
                   S_RW = 5, S_SD = 6, S_RD = 7;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            S_A:     return ALU_A;
            S_B:     return ALU_B;
            S_CTL:   return 32'(ALU_Control);
            S_VLD:   return 32'(ex_valid);
            S_STALL: return 32'(stall_o);
            S_RW:    return 32'(ex_reg_write);
            S_SD:    return ex_store_data;
            default: return 32'(ex_rd);
        endcase
    endfunction

    // Monitor: pop every expectation that targets this falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] act;
        cyc = cyc + 1;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            vectors = vectors + 1;
            act = probe(e.sel);
            if (e.cyc < cyc) begin
                miscompares = miscompares + 1;
                $display("FAIL %s: sample missed at cycle %0d", e.name, cyc);
            end else if (act !== e.val) begin
                miscompares = miscompares + 1;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
            end
        end
    end

    // Expect a value at the next falling edge.
    task automatic expect_nx(input int sel, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc = cyc + 1;
        e.sel = sel;
        e.val = val;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_uses_rs2 = 0; id_a_pc = 0;
        id_alu_src = 0; id_alu_op = 2'b00; id_funct3 = 3'b000; id_funct7_5 = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        id_branch = 0;
    endtask

    task automatic no_fwd();
        exmem_reg_write = 0; exmem_rd = '0; exmem_result = '0;
        memwb_reg_write = 0; memwb_rd = '0; memwb_result = '0;
    endtask

    task automatic expect_reset(input string tag);
        expect_nx(S_A, 32'h0, {tag, "_alu_a"});
        expect_nx(S_B, 32'h0, {tag, "_alu_b"});
        expect_nx(S_CTL, 32'h2, {tag, "_ctl"});
        expect_nx(S_VLD, 32'h0, {tag, "_valid"});
        expect_nx(S_STALL, 32'h0, {tag, "_stall"});
        expect_nx(S_RD, 32'h0, {tag, "_rd"});
    endtask

    logic [1:0] t_op [11] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [2:0] t_f3 [11] = '{3'b000, 3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b001, 3'b001, 3'b000, 3'b010, 3'b110};
    logic       t_f7 [11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] t_ex [11] = '{4'h2, 4'h6, 4'h2, 4'h0, 4'h1, 4'h7, 4'hF, 4'hF, 4'h2, 4'h7, 4'h1};

    initial begin
        rst_n = 0; hold_i = 0; flush_i = 0;
        idle_id();
        no_fwd();
        repeat (2) tick();
        rst_n = 1;
        expect_reset("reset");

        // R-type SUB
        tick();
        id_valid = 1; id_alu_op = 2'b10; id_funct3 = 3'b000; id_funct7_5 = 1;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rs1_data = 32'd9; id_rs2_data = 32'd4;
        id_rd = 5'd3; id_reg_write = 1; id_uses_rs2 = 1;
        tick();
        idle_id();
        expect_nx(S_CTL, 32'h6, "rtype_sub_ctl");
        expect_nx(S_A, 32'd9, "rtype_alu_a");
        expect_nx(S_B, 32'd4, "rtype_alu_b");
        expect_nx(S_VLD, 32'h1, "rtype_valid");
        expect_nx(S_RW, 32'h1, "rtype_reg_write");
        expect_nx(S_RD, 32'd3, "rtype_rd");

        // Double forward, with hold keeping EX while ID changes
        tick();
        id_valid = 1; id_rs1 = 5'd5; id_rs1_data = 32'h99; id_rs2 = 5'd5;
        id_rs2_data = 32'h77; id_alu_src = 1; id_imm = 32'h40; id_alu_op = 2'b00;
        tick();
        idle_id();
        id_valid = 1; id_rs1 = 5'd9; id_rs1_data = 32'h55;
        hold_i = 1;
        exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'h22;
        expect_nx(S_A, 32'h11, "fwd_both_alu_a");
        expect_nx(S_B, 32'h40, "fwd_imm_alu_b");
        expect_nx(S_SD, 32'h11, "fwd_both_store");
        expect_nx(S_STALL, 32'h1, "hold_stall");
        tick();
        exmem_rd = '0;
        expect_nx(S_A, 32'h22, "fwd_memwb_alu_a");
        expect_nx(S_SD, 32'h22, "fwd_memwb_store");
        tick();
        hold_i = 0;
        no_fwd();
        idle_id();
        tick();

        // ALU control decode table
        for (int i = 0; i < 11; i++) begin
            id_valid = 1; id_alu_op = t_op[i]; id_funct3 = t_f3[i]; id_funct7_5 = t_f7[i];
            tick();
            expect_nx(S_CTL, 32'(t_ex[i]), $sformatf("decode_%0d", i));
        end
        idle_id();
        tick();

        // Load-use hazard: lw x7 then add x8, x3, x7
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1;
        id_rd = 5'd7; id_rs1 = 5'd2; id_alu_src = 1; id_imm = 32'h4;
        tick();
        idle_id();
        id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1;
        id_rs1_data = 32'h10; id_rs2_data = 32'hDEAD; id_alu_op = 2'b10;
        id_rd = 5'd8; id_reg_write = 1;
        expect_nx(S_STALL, 32'h1, "load_use_stall");
        tick();
        expect_nx(S_VLD, 32'h0, "load_use_bubble_valid");
        expect_nx(S_RW, 32'h0, "load_use_bubble_rw");
        expect_nx(S_STALL, 32'h0, "load_use_stall_clear");
        tick();
        idle_id();
        memwb_reg_write = 1; memwb_rd = 5'd7; memwb_result = 32'h1234;
        expect_nx(S_VLD, 32'h1, "load_use_add_valid");
        expect_nx(S_B, 32'h1234, "load_use_alu_b");
        expect_nx(S_A, 32'h10, "load_use_alu_a");
        expect_nx(S_RD, 32'd8, "load_use_rd");

        // Flush wins over hold
        tick();
        no_fwd();
        id_valid = 1; id_rs1 = 5'd4; id_rs1_data = 32'h66; id_reg_write = 1;
        flush_i = 1; hold_i = 1;
        expect_nx(S_STALL, 32'h0, "flush_hold_stall");
        tick();
        flush_i = 0; hold_i = 0;
        idle_id();
        expect_nx(S_VLD, 32'h0, "flush_valid");
        expect_nx(S_RW, 32'h0, "flush_reg_write");
        expect_nx(S_CTL, 32'h2, "flush_ctl");

        // Load in EX but ID does not read rs2: no stall
        tick();
        id_valid = 1; id_mem_read = 1; id_rd = 5'd7; id_reg_write = 1;
        tick();
        idle_id();
        id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd7; id_uses_rs2 = 0;
        expect_nx(S_STALL, 32'h0, "no_rs2_use_stall");

        // Mid-operation reset clears without a clock edge
        tick();
        idle_id();
        id_valid = 1; id_alu_op = 2'b01; id_rs1 = 5'd1; id_rs1_data = 32'h3; id_rd = 5'd2;
        tick();
        idle_id();
        #2;
        rst_n = 0;
        expect_reset("midreset");
        tick();
        rst_n = 1;

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && q.size() > 0; k++) tick();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL %s: never sampled, expected 0x%0h", e.name, e.val);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
